// File: rtl/parser_pkg.sv
// Shared types and constants for the parser input arbiter.
package parser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Parser input beat geometry for the default build.
  localparam int IP_DATA_WIDTH_DEF = 64;
  localparam int BYTES_PER_BEAT    = IP_DATA_WIDTH_DEF / 8;

  // Port index width; never narrower than one bit.
  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner search: first set request strictly after last_grant,
// wrapping at NUM_PORTS-1.
module rr_picker
  import parser_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IW        = port_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last_grant,
  output logic [IW-1:0]        winner,
  output logic                 found
);

  logic [IW-1:0] idx;

  // Walk the ports once, starting after last_grant, keep the first hit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = last_grant;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (idx == IW'(NUM_PORTS - 1)) ? '0 : idx + IW'(1);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/parser_input_arb.sv
// Payload-level round-robin arbiter in front of the message parser.
// A port wins on its sop beat and keeps the grant through eop; GAP_CYCLES
// idle cycles follow every payload. Optional stall watchdog is enabled with
// `define PARSER_ARB_WATCHDOG_EN.
module parser_input_arb
  import parser_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int IP_DATA_WIDTH = 64,
  parameter int GAP_CYCLES    = 1,
  parameter int TIMEOUT       = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS-1:0]               req_sop,
  input  logic [NUM_PORTS-1:0]               req_eop,
  input  logic [NUM_PORTS*IP_DATA_WIDTH-1:0] req_data,
  input  logic [NUM_PORTS-1:0]               req_empty,
  input  logic [NUM_PORTS-1:0]               req_error,
  output logic [NUM_PORTS-1:0]               req_ready,
  output logic                               out_valid,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic                               out_empty,
  output logic                               out_error,
  output logic [IP_DATA_WIDTH-1:0]           out_data,
  input  logic                               out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]       grant_id,
  output logic                               busy,
  output logic [NUM_PORTS-1:0]               drop_flag
);

  localparam int IW = port_idx_w(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
    $error("parser_input_arb: NUM_PORTS must be 2..8");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 7) begin : g_bad_gap
    $error("parser_input_arb: GAP_CYCLES must be 0..7");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("parser_input_arb: TIMEOUT must be at least 1");
  end

  arb_state_t                               state_q;
  logic [IW-1:0]                            grant_q;
  logic [IW-1:0]                            last_grant_q;
  logic [2:0]                               gap_cnt_q;
  logic [NUM_PORTS-1:0]                     drop_q;
  logic [IW-1:0]                            pick_idx;
  logic                                     pick_found;
  logic [NUM_PORTS-1:0]                     eligible;
  logic [NUM_PORTS-1:0]                     gmask;
  logic [NUM_PORTS-1:0]                     own_mask;
  logic [NUM_PORTS-1:0]                     stray;
  logic [NUM_PORTS-1:0][IP_DATA_WIDTH-1:0]  data_vec;
  logic                                     run;
  logic                                     fwd;
  logic                                     g_valid;
  logic                                     synth;
  logic                                     xfer;

  assign data_vec  = req_data;
  assign eligible  = req_valid & req_sop;
  assign run       = !reset;
  assign fwd       = run && (state_q == FWD);
  assign g_valid   = req_valid[grant_q];
  assign grant_id  = grant_q;
  assign busy      = fwd;
  assign drop_flag = drop_q;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_picker (
    .req        (eligible),
    .last_grant (last_grant_q),
    .winner     (pick_idx),
    .found      (pick_found)
  );

  // One-hot view of the granted port.
  always_comb begin
    gmask          = '0;
    gmask[grant_q] = 1'b1;
  end

  // Non-sop beats on any port that does not own the parser are swallowed;
  // in IDLE nobody owns it, in FWD/GAP the granted port does.
  assign own_mask  = (state_q == IDLE) ? '0 : gmask;
  assign stray     = req_valid & ~req_sop & ~own_mask & {NUM_PORTS{run}};
  assign req_ready = stray | ((fwd && !synth) ? (gmask & {NUM_PORTS{out_ready}}) : '0);

  // Parser-side mux: pass the granted port through, or the synthetic
  // error beat while the watchdog is closing a stalled payload.
  always_comb begin
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = 1'b0;
    out_error = 1'b0;
    out_data  = '0;
    if (fwd) begin
      if (synth) begin
        out_valid = 1'b1;
        out_eop   = 1'b1;
        out_error = 1'b1;
      end else begin
        out_valid = g_valid;
        out_sop   = req_sop[grant_q];
        out_eop   = req_eop[grant_q];
        out_empty = req_empty[grant_q];
        out_error = req_error[grant_q];
        out_data  = data_vec[grant_q];
      end
    end
  end

  assign xfer = out_valid && out_ready;

`ifdef PARSER_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt_q;

  assign synth = fwd && (wd_cnt_q == WW'(TIMEOUT));

  // Count consecutive idle cycles of the granted port; saturate at TIMEOUT
  // so the synthetic beat is held until the parser takes it.
  always_ff @(posedge clk) begin
    if (reset || state_q != FWD) begin
      wd_cnt_q <= '0;
    end else if (!synth) begin
      if (g_valid) wd_cnt_q <= '0;
      else         wd_cnt_q <= wd_cnt_q + WW'(1);
    end
  end
`else
  assign synth = 1'b0;
`endif

  // Arbitration FSM: IDLE picks, FWD forwards until eop, GAP idles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_PORTS - 1);
      gap_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            state_q <= FWD;
          end
        end
        FWD: begin
          if (xfer && out_eop) begin
            last_grant_q <= grant_q;
            gap_cnt_q    <= '0;
            state_q      <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_cnt_q == 3'(GAP_CYCLES - 1)) state_q <= IDLE;
          else                                  gap_cnt_q <= gap_cnt_q + 3'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky per-port record of discarded beats (strays and watchdog aborts).
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_q | stray | ((synth && xfer) ? gmask : '0);
    end
  end

endmodule
